// File: rtl/icache_pkg.sv
// ------------------------------------------------------------------
// icache_pkg : shared state encoding and address-field widths for icache_dm
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // 32-bit byte address minus the 2-bit byte offset, word offset and index
  function automatic int tag_w(input int lines, input int words);
    return 30 - off_w(words) - idx_w(lines);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_line_store.sv
// ------------------------------------------------------------------
// icache_line_store : valid/tag/data arrays with combinational read port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module icache_line_store
  import icache_pkg::*;
#(
  parameter  int LINES = 8,
  parameter  int WORDS = 4,
  localparam int OFF_W = off_w(WORDS),
  localparam int IDX_W = idx_w(LINES),
  localparam int TAG_W = tag_w(LINES, WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_word,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFF_W-1:0] i_wr_word,
  input  logic [31:0]      i_wr_data,
  input  logic             i_tag_we,
  input  logic [TAG_W-1:0] i_tag_data,
  input  logic             i_flush
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

  // Flush takes priority so a line completing in the flush cycle stays invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_word] <= i_wr_data;
    end
    if (i_tag_we) begin
      r_tag[i_wr_idx] <= i_tag_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_dm.sv
// ------------------------------------------------------------------
// icache_dm : direct-mapped read-only instruction cache with line refill
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int WORDS = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             rd_req,
  input  logic             flush,
  output logic [31:0]      instr,
  output logic             hit,
  output logic             stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OFF_W = off_w(WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);

  localparam logic [OFF_W-1:0] C_LAST_WORD = OFF_W'(WORDS - 1);
  localparam logic [OFF_W-1:0] C_WORD_ONE  = OFF_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_miss_count;

  logic [OFF_W-1:0] w_pc_word;
  logic [IDX_W-1:0] w_pc_idx;
  logic [TAG_W-1:0] w_pc_tag;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_data;
  logic             w_idle;
  logic             w_hit;
  logic             w_fill_ready;
  logic             w_fill_last;
  logic             w_unused;

  assign w_pc_word = pc[OFF_W+1:2];
  assign w_pc_idx  = pc[OFF_W+IDX_W+1:OFF_W+2];
  assign w_pc_tag  = pc[31:OFF_W+IDX_W+2];
  assign w_unused  = ^pc[1:0];

  assign w_idle       = (r_state == ST_IDLE);
  assign w_hit        = w_idle & rd_req & w_rd_valid & (w_rd_tag == w_pc_tag);
  assign w_fill_ready = ~w_idle & mem_ready & ~flush;
  assign w_fill_last  = w_fill_ready & (r_cnt == C_LAST_WORD);

  assign hit        = w_hit;
  assign instr      = w_hit ? w_rd_data : 32'd0;
  assign stall      = w_idle ? (rd_req & ~w_hit) : 1'b1;
  assign mem_req    = ~w_idle;
  assign mem_addr   = w_idle ? 32'd0 : {r_tag, r_idx, r_cnt, 2'b00};
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  icache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_pc_idx),
    .i_rd_word  (w_pc_word),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill_ready),
    .i_wr_idx   (r_idx),
    .i_wr_word  (r_cnt),
    .i_wr_data  (mem_rdata),
    .i_tag_we   (w_fill_last),
    .i_tag_data (r_tag),
    .i_flush    (flush)
  );

  // Valid bits are cleared inside the line store; flush here only aborts a fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_req) begin
            if (w_hit) begin
              r_hit_count <= r_hit_count + C_CNT_ONE;
            end else begin
              r_tag        <= w_pc_tag;
              r_idx        <= w_pc_idx;
              r_cnt        <= '0;
              r_miss_count <= r_miss_count + C_CNT_ONE;
              r_state      <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (mem_ready) begin
            r_cnt <= r_cnt + C_WORD_ONE;
            if (r_cnt == C_LAST_WORD) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ------------------------------------------------------------------
// tb_icache_dm : randomized self-checking bench for icache_dm
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_icache_dm;

  localparam int LINES = 8;
  localparam int WORDS = 4;
  localparam int CNT_W = 32;
  localparam int LINE_BYTES = WORDS * 4;

  logic             clk;
  logic             rst;
  logic [31:0]      pc;
  logic             rd_req;
  logic             flush;
  logic [31:0]      instr;
  logic             hit;
  logic             stall;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             mem_ready;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  icache_dm #(
    .LINES (LINES),
    .WORDS (WORDS),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .rd_req     (rd_req),
    .flush      (flush),
    .instr      (instr),
    .hit        (hit),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: which aligned line block each cache slot holds, plus counters
  bit          m_valid [LINES];
  logic [31:0] m_base  [LINES];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_base[line_of(a)] == base_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_counters();
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  // Drives one refill; mode 0 ready every cycle, 1 every 3rd cycle, 2 random.
  // flush_after >= 0 asserts flush once that many words have been accepted.
  task automatic fill(input logic [31:0] a, input int mode, input int flush_after);
    logic [31:0] base;
    int lat;
    base = base_of(a);
    for (int w = 0; w < WORDS; w++) begin
      if (w == flush_after) begin
        @(negedge clk);
        flush = 1'b1; mem_ready = 1'b1; mem_rdata = memfn(base + 32'(4 * w));
        rd_req = 1'($urandom); pc = $urandom;
        #1;
        check("mem_req_flush_cycle", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        flush = 1'b0; mem_ready = 1'b0; rd_req = 1'b0;
        #1;
        check("mem_req_after_flush", {31'd0, mem_req}, 32'd0);
        check("stall_after_flush", {31'd0, stall}, 32'd0);
        return;
      end
      lat = (mode == 0) ? 1 : (mode == 1) ? 3 : int'($urandom_range(1, 3));
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        pc = $urandom; rd_req = 1'($urandom); flush = 1'b0;
        mem_ready = (c == lat);
        mem_rdata = (c == lat) ? memfn(base + 32'(4 * w)) : $urandom;
        #1;
        check("fill_mem_req", {31'd0, mem_req}, 32'd1);
        check("fill_mem_addr", mem_addr, base + 32'(4 * w));
        check("fill_stall", {31'd0, stall}, 32'd1);
        check("fill_hit", {31'd0, hit}, 32'd0);
        check("fill_instr", instr, 32'd0);
        @(posedge clk);
      end
    end
    m_valid[line_of(a)] = 1'b1;
    m_base[line_of(a)]  = base;
  endtask

  task automatic access(input logic [31:0] a, input int mode, input int flush_after);
    @(negedge clk);
    pc = a; rd_req = 1'b1; flush = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    check_counters();
    if (m_hit(a)) begin
      check("hit", {31'd0, hit}, 32'd1);
      check("instr", instr, memfn(a & ~32'd3));
      check("stall", {31'd0, stall}, 32'd0);
      check("mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      m_hits++;
    end else begin
      check("miss_hit", {31'd0, hit}, 32'd0);
      check("miss_stall", {31'd0, stall}, 32'd1);
      check("miss_instr", instr, 32'd0);
      check("miss_mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      m_misses++;
      fill(a, mode, flush_after);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    pc = $urandom; rd_req = 1'b0; flush = 1'b0; mem_ready = 1'($urandom);
    #1;
    check("idle_hit", {31'd0, hit}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_instr", instr, 32'd0);
    check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    check_counters();
    @(posedge clk);
  endtask

  // Flush in IDLE; the lookup in the same cycle still sees pre-flush valids
  task automatic flush_idle(input logic [31:0] a);
    @(negedge clk);
    pc = a; rd_req = m_hit(a); flush = 1'b1; mem_ready = 1'b0;
    #1;
    check("flush_idle_hit", {31'd0, hit}, {31'd0, m_hit(a)});
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    if (m_hit(a)) m_hits++;
    model_clear();
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    @(negedge clk);
    pc = a; rd_req = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_pre_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = memfn(base_of(a) + 32'(4 * w));
      @(posedge clk);
    end
    #2;
    rst = 1'b1; rd_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    model_clear();
    m_hits = '0;
    m_misses = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int fa;
    rst = 1'b1; pc = '0; rd_req = 1'b0; flush = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    model_clear();
    m_hits = '0;
    m_misses = '0;
    #2;
    check("reset_hit", {31'd0, hit}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_instr", instr, 32'd0);
    check_counters();
    @(negedge clk);
    rst = 1'b0;

    // Cold miss then line hits
    access(32'h0, 0, -1);
    access(32'h0, 0, -1);
    access(32'h4, 0, -1);
    access(32'h8, 0, -1);
    access(32'hC, 0, -1);
    idle_cycle();

    // Conflict eviction on index 0
    access(32'h80, 0, -1);
    access(32'h8C, 0, -1);
    access(32'h0, 0, -1);
    access(32'h3, 0, -1);

    // Slow memory: the following access must hit immediately
    access(32'h104, 1, -1);
    access(32'h108, 0, -1);

    // Flush in IDLE then re-miss
    flush_idle(32'h0);
    access(32'h0, 0, -1);
    access(32'h0, 0, -1);

    // Flush after 2nd ready, then flush coinciding with final ready
    access(32'h44, 0, 2);
    access(32'h44, 0, WORDS - 1);
    access(32'h44, 0, -1);
    access(32'h48, 0, -1);

    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      a  = 32'($urandom_range(0, 255)) << 2;
      a  = a | 32'($urandom_range(0, 3));
      fa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
      access(a, 2, fa);
      if ($urandom_range(0, 9) == 0) idle_cycle();
      if ($urandom_range(0, 29) == 0) flush_idle(a);
    end

    // Async reset mid-fill, then first access must miss
    reset_mid_fill(32'h20);
    access(32'h20, 0, -1);
    access(32'h20, 0, -1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage (PC) and the backing instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses stall fetch and refill one full line, one word per memory handshake.
- Provides performance counters and an invalidate-all (flush) input for the miss-penalty experiments.

Parameters:
- LINES, 8, number of cache lines; power of two, 2 or more.
- WORDS, 4, 32-bit words per line; power of two, 2 or more.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc  in  32  byte address from fetch; bits [1:0] ignored.
- rd_req  in  1  fetch requests an instruction this cycle.
- flush  in  1  invalidate all lines.
- instr  out  32  instruction; valid only when hit=1, otherwise 0.
- hit  out  1  instr valid this cycle.
- stall  out  1  fetch must hold its PC.
- mem_req  out  1  refill word request.
- mem_addr  out  32  byte address of the requested word.
- mem_rdata  in  32  memory data for mem_addr.
- mem_ready  in  1  mem_rdata valid; consumes one word.
- hit_count  out  CNT_W  number of hit cycles.
- miss_count  out  CNT_W  number of misses detected.

Behaviour:
- Address split: [1:0] byte offset; next log2(WORDS) bits word offset; next log2(LINES) bits index; remaining bits tag.
- Storage: valid[LINES], tag[LINES], data[LINES][WORDS]. No reset of the tag or data arrays.
- States: IDLE and FILL.
- IDLE
  - hit = rd_req & valid[idx] & (tag[idx] == pc tag). On hit, instr = data[idx][word].
  - stall = rd_req & ~hit.
  - mem_req = 0.
  - Miss: latch pc line address (tag and index), clear word counter, miss_count++ and go to FILL.
  - Hit: hit_count++.
- FILL
  - stall = 1, hit = 0, instr = 0, mem_req = 1.
  - mem_addr = {latched tag, latched index, cnt, 2'b00}.
  - mem_addr and mem_req are held until mem_ready.
  - On mem_ready: data[idx][cnt] <= mem_rdata and cnt++.
  - On mem_ready with cnt == WORDS-1: set valid[idx] and tag[idx], then return to IDLE.
  - pc and rd_req are ignored during FILL.
- After FILL the next IDLE cycle re-evaluates the current pc. The faulting access therefore hits one cycle after the last mem_ready.
- Miss penalty: sum of the WORDS handshake latencies + 1 cycle.
- flush
  - In IDLE: all valid bits are cleared at the edge. The lookup in that same cycle still uses the pre-flush valid bits.
  - In FILL: the fill is aborted, all valid bits are cleared, and the block returns to IDLE. The line is never validated and mem_req drops after the edge.
- Flush and the final mem_ready arriving in the same cycle: flush wins and the line stays invalid.
- rd_req=0 in IDLE: hit=0, stall=0, instr=0, no counter change.
- Counters wrap modulo 2^CNT_W.
- Reset: state=IDLE, all valid=0, cnt=0, hit_count=0, miss_count=0. Outputs immediately read hit=0, stall=0, mem_req=0, mem_addr=0, instr=0.
- Reset mid-FILL aborts the fill with no clock edge required.

Decomposition:
- Shared package icache_pkg holds:
  - the state encoding (IDLE, FILL);
  - address-field width functions (OFF_W, IDX_W, TAG_W derived from LINES and WORDS).
- One natural sub-module, icache_line_store:
  - valid/tag/data arrays;
  - combinational read port (idx, word);
  - word write port;
  - tag-write-with-valid port;
  - flush-all port.
- The controller FSM and counters stay in icache_dm.

Test Plan:
- Cold miss: rst, then rd_req=1 with pc=0x0 and mem_ready=1 every cycle.
  - stall=1 and mem_addr steps 0x0, 0x4, 0x8, 0xC over 4 cycles.
  - The next cycle gives hit=1 with instr = word at 0x0, and miss_count=1.
- Line hits: following the cold miss, pc=0x4, 0x8, 0xC consecutively.
  - hit=1 each cycle, stall=0 and mem_req=0; hit_count goes to 4 (including the post-fill hit).
- Conflict eviction: with pc=0x80 (index 0, new tag).
  - The access misses and refills addresses 0x80 to 0x8C.
  - A following pc=0x0 misses again, so miss_count=3.
- Slow memory: mem_ready high only every 3rd cycle.
  - mem_addr is held stable between readies and stall=1 throughout.
  - hit occurs 13 cycles after the miss is detected.
- Flush: flush in IDLE after a fill, then pc=0x0 misses.
  - flush asserted after the 2nd mem_ready of a fill gives mem_req=0 on the next cycle.
  - Re-access of that line misses.
- Async reset mid-FILL: assert rst between edges.
  - mem_req, stall and both counters read 0 immediately, and the first access after reset misses.
